// File: rtl/prco_fetch_if.sv
// Instruction-memory port of the PRCO fetch stage.
// The fetch stage owns the request side; memory owns the data/valid side.
interface prco_fetch_if;
  logic [15:0] q_imem_addr;
  logic        q_imem_rd;
  logic [15:0] i_imem_data;
  logic        i_imem_valid;

  modport master (output q_imem_addr, q_imem_rd, input i_imem_data, i_imem_valid);
  modport slave  (input q_imem_addr, q_imem_rd, output i_imem_data, i_imem_valid);
endinterface

// File: rtl/prco_fetch.sv
// PRCO instruction fetch: PC, imem request handshake, one-cycle q_ce strobe to decoder.
// Define PRCO_FETCH_PREFETCH_EN to add a one-word prefetch buffer.
//
// state   | meaning
// IDLE    | waiting for i_fetch / pending (or a buffered word to hand out)
// REQ     | drive q_imem_rd for f_pc (held here while i_en is low)
// WAIT    | request outstanding, waiting for i_imem_valid
// ISSUE   | captured word held because i_en was low at capture
// HALT    | absorbing; only reset leaves
module prco_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  prco_fetch_if.master      imem,
  input  logic              i_en,
  input  logic              i_fetch,
  input  logic              i_halt,
  input  logic              i_jmp_en,
  input  logic [15:0]       i_jmp_addr,
  output logic              q_ce,
  output logic [15:0]       q_instr,
  output logic [15:0]       q_pc,
  output logic              q_halted
);

`ifdef PRCO_FETCH_PREFETCH_EN
  localparam bit PF_EN = 1'b1;
`else
  localparam bit PF_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ISSUE, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [15:0] f_pc_q, f_pc_d;
  logic [15:0] addr_q, addr_d;
  logic        pend_q, pend_d;
  logic        drop_q, drop_d;
  logic        pf_q, pf_d;
  logic [15:0] word_q, word_d;
  logic        ce_q, ce_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_q, pc_d;
  logic        buf_v_q, buf_v_d;
  logic [15:0] buf_q, buf_d;
  logic [15:0] buf_pc_q, buf_pc_d;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= S_REQ;
      f_pc_q   <= RESET_PC;
      addr_q   <= RESET_PC;
      pend_q   <= 1'b0;
      drop_q   <= 1'b0;
      pf_q     <= 1'b0;
      word_q   <= 16'h0000;
      ce_q     <= 1'b0;
      instr_q  <= 16'h0000;
      pc_q     <= RESET_PC;
      buf_v_q  <= 1'b0;
      buf_q    <= 16'h0000;
      buf_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      f_pc_q   <= f_pc_d;
      addr_q   <= addr_d;
      pend_q   <= pend_d;
      drop_q   <= drop_d;
      pf_q     <= pf_d;
      word_q   <= word_d;
      ce_q     <= ce_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      buf_v_q  <= buf_v_d;
      buf_q    <= buf_d;
      buf_pc_q <= buf_pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    f_pc_d   = f_pc_q;
    addr_d   = addr_q;
    pend_d   = pend_q;
    drop_d   = drop_q;
    pf_d     = pf_q;
    word_d   = word_q;
    ce_d     = 1'b0;
    instr_d  = instr_q;
    pc_d     = pc_q;
    buf_v_d  = buf_v_q;
    buf_d    = buf_q;
    buf_pc_d = buf_pc_q;

    if (i_halt) begin
      state_d = S_HALT;
      buf_v_d = 1'b0;
    end else begin
      if (state_q != S_IDLE && state_q != S_HALT && i_fetch)
        pend_d = 1'b1;
      if (state_q != S_HALT && i_jmp_en) begin
        f_pc_d  = i_jmp_addr;
        buf_v_d = 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (i_jmp_en) begin
            if (i_fetch) pend_d = 1'b1;
          end else if ((i_fetch || pend_q) && i_en) begin
            pend_d  = 1'b0;
            state_d = S_REQ;
            pf_d    = 1'b0;
            if (PF_EN && buf_v_q) begin
              // hand out the buffered word now and refill behind it
              ce_d    = 1'b1;
              instr_d = buf_q;
              pc_d    = buf_pc_q;
              buf_v_d = 1'b0;
              pf_d    = 1'b1;
            end
          end else if (i_fetch) begin
            pend_d = 1'b1;
          end
        end
        S_REQ: begin
          if (i_en) begin
            addr_d  = f_pc_q;
            state_d = S_WAIT;
            if (i_jmp_en) drop_d = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem.i_imem_valid) begin
            if (drop_q || i_jmp_en) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              f_pc_d = f_pc_q + 16'd1;
              if (pf_q) begin
                buf_d    = imem.i_imem_data;
                buf_pc_d = addr_q;
                buf_v_d  = 1'b1;
                state_d  = S_IDLE;
              end else if (i_en) begin
                // issue straight from the bus so q_ce lands one cycle after valid
                ce_d    = 1'b1;
                instr_d = imem.i_imem_data;
                pc_d    = addr_q;
                state_d = PF_EN ? S_REQ : S_IDLE;
                pf_d    = PF_EN;
              end else begin
                word_d  = imem.i_imem_data;
                state_d = S_ISSUE;
              end
            end
          end else if (i_jmp_en) begin
            drop_d = 1'b1;
          end
        end
        S_ISSUE: begin
          if (i_jmp_en) begin
            state_d = S_REQ;
            pf_d    = 1'b0;
          end else if (i_en) begin
            ce_d    = 1'b1;
            instr_d = word_q;
            pc_d    = addr_q;
            state_d = PF_EN ? S_REQ : S_IDLE;
            pf_d    = PF_EN;
          end
        end
        default: state_d = S_HALT;
      endcase
    end
  end

  // reset holds state at REQ, so the read strobe is masked while reset is low
  assign imem.q_imem_rd   = (state_q == S_REQ) && i_en && i_reset;
  assign imem.q_imem_addr = (state_q == S_REQ) ? f_pc_q : addr_q;
  assign q_ce             = ce_q;
  assign q_instr          = instr_q;
  assign q_pc             = pc_q;
  assign q_halted         = (state_q == S_HALT);

endmodule

// File: tb/tb_prco_fetch.sv
// Directed bench for prco_fetch with a variable-latency instruction memory model.
// Covers the default build; PRCO_FETCH_PREFETCH_EN selects the prefetch-buffer vectors.
module tb_prco_fetch;
  logic        clk = 1'b0;
  logic        rst_n, en, fetch, halt, jmp_en;
  logic [15:0] jmp_addr;
  logic        ce, halted;
  logic [15:0] instr, pc;

  always #5 clk = ~clk;

  prco_fetch_if bus();

  prco_fetch #(.RESET_PC(16'h0000)) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .imem       (bus),
    .i_en       (en),
    .i_fetch    (fetch),
    .i_halt     (halt),
    .i_jmp_en   (jmp_en),
    .i_jmp_addr (jmp_addr),
    .q_ce       (ce),
    .q_instr    (instr),
    .q_pc       (pc),
    .q_halted   (halted)
  );

  int n_vec = 0;
  int n_err = 0;
  int lat = 1;
  int cyc = 0, rd_cnt = 0, rd_cyc = 0, ce_cnt = 0, ce_cyc = 0, fetch_cyc = 0;
  int addr_err = 0, dbl = 0;
  logic [15:0] ce_instr, ce_pc;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0000) return 16'h4105;
    return {~a[7:0], a[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ce(input int base);
    int t = 0;
    while (ce_cnt <= base && t < 100) begin
      @(negedge clk); #2;
      t++;
    end
    chk("ce_timeout", ce_cnt > base, 1);
  endtask

  task automatic pulse_fetch();
    @(negedge clk); fetch = 1'b1;
    @(negedge clk); fetch = 1'b0;
  endtask

  // memory model and event monitor, sampling just after each falling edge
  initial begin
    int cnt = 0;
    bit busy = 0;
    bit ce_prev = 0;
    logic [15:0] req_addr = 16'h0000;
    bus.i_imem_valid = 1'b0;
    bus.i_imem_data  = 16'h0000;
    forever begin
      @(negedge clk); #1;
      cyc++;
      bus.i_imem_valid = 1'b0;
      if (!rst_n) begin
        busy = 0;
        ce_prev = 0;
      end else begin
        if (busy) begin
          cnt--;
          if (cnt == 0) begin
            bus.i_imem_valid = 1'b1;
            bus.i_imem_data  = mem_word(req_addr);
            busy = 0;
          end else if (bus.q_imem_addr !== req_addr) begin
            addr_err++;
          end
        end
        if (bus.q_imem_rd) begin
          busy = 1; cnt = lat; req_addr = bus.q_imem_addr;
          rd_cnt++; rd_cyc = cyc;
        end
        if (ce) begin
          if (ce_prev) dbl++;
          ce_cnt++; ce_cyc = cyc; ce_instr = instr; ce_pc = pc;
        end
        ce_prev = ce;
        if (fetch) fetch_cyc = cyc;
      end
    end
  end

  initial begin
    int s, r;
    logic [15:0] exp_w [1:4] = '{16'hFE01, 16'hFD02, 16'hFC03, 16'hFB04};
    rst_n = 1'b0; en = 1'b1; fetch = 1'b0; halt = 1'b0; jmp_en = 1'b0; jmp_addr = 16'h0000;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_ce", ce, 0);
    chk("rst_rd", bus.q_imem_rd, 0);
    chk("rst_halted", halted, 0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_addr", bus.q_imem_addr, 16'h0000);

    @(negedge clk); rst_n = 1'b1; #2;
    chk("boot_rd", bus.q_imem_rd, 1);
    chk("boot_addr", bus.q_imem_addr, 16'h0000);
    wait_ce(0);
    chk("boot_instr", ce_instr, 16'h4105);
    chk("boot_pc", ce_pc, 16'h0000);
    chk("boot_lat", ce_cyc - rd_cyc, 2);

`ifdef PRCO_FETCH_PREFETCH_EN
    repeat (8) @(negedge clk);
    #2;
    chk("pf_fill_rd", rd_cnt, 2);
    s = ce_cnt;
    pulse_fetch();
    wait_ce(s);
    chk("pf_hit_lat", ce_cyc - fetch_cyc, 1);
    chk("pf_hit_pc", ce_pc, 16'h0001);
    chk("pf_hit_instr", ce_instr, 16'hFE01);
    repeat (8) @(negedge clk);
    jmp_en = 1'b1; jmp_addr = 16'h0040;
    @(negedge clk); jmp_en = 1'b0;
    repeat (2) @(negedge clk);
    s = ce_cnt;
    pulse_fetch();
    wait_ce(s);
    chk("pf_jmp_pc", ce_pc, 16'h0040);
    chk("pf_jmp_instr", ce_instr, 16'hBF40);
    repeat (8) @(negedge clk);
    #2;
    chk("pf_jmp_cnt", ce_cnt - s, 1);
`else
    lat = 3;
    for (int k = 1; k <= 4; k++) begin
      s = ce_cnt;
      pulse_fetch();
      wait_ce(s);
      chk("fetch_pc", ce_pc, k);
      chk("fetch_instr", ce_instr, exp_w[k]);
      chk("fetch_lat", ce_cyc - fetch_cyc, 5);
    end

    // jump while the request for address 5 is outstanding
    s = ce_cnt;
    pulse_fetch();
    @(negedge clk); jmp_en = 1'b1; jmp_addr = 16'h0040;
    @(negedge clk); jmp_en = 1'b0;
    wait_ce(s);
    chk("jmp_refetch_cyc", rd_cyc - fetch_cyc, 5);
    chk("jmp_pc", ce_pc, 16'h0040);
    chk("jmp_instr", ce_instr, 16'hBF40);
    repeat (6) @(negedge clk);
    #2;
    chk("jmp_ce_cnt", ce_cnt - s, 1);

    // enable dropped while waiting: capture completes, strobe waits for i_en
    s = ce_cnt;
    pulse_fetch();
    @(negedge clk); en = 1'b0;
    repeat (8) @(negedge clk);
    #2;
    chk("en_hold", ce_cnt - s, 0);
    @(negedge clk); en = 1'b1;
    wait_ce(s);
    chk("en_pc", ce_pc, 16'h0041);
    chk("en_instr", ce_instr, 16'hBE41);

    // PC wrap
    lat = 1;
    @(negedge clk); jmp_en = 1'b1; jmp_addr = 16'hFFFF;
    @(negedge clk); jmp_en = 1'b0;
    s = ce_cnt;
    pulse_fetch();
    wait_ce(s);
    chk("wrap_pc0", ce_pc, 16'hFFFF);
    chk("wrap_instr0", ce_instr, 16'h00FF);
    s = ce_cnt;
    pulse_fetch();
    wait_ce(s);
    chk("wrap_pc1", ce_pc, 16'h0000);
    chk("wrap_instr1", ce_instr, 16'h4105);
`endif

    // halt with a request in flight
    lat = 3;
    repeat (4) @(negedge clk);
    pulse_fetch();
    @(negedge clk); halt = 1'b1;
    @(negedge clk); halt = 1'b0;
    #2;
    s = ce_cnt; r = rd_cnt;
    repeat (20) @(negedge clk);
    #2;
    chk("halt_flag", halted, 1);
    chk("halt_no_rd", rd_cnt - r, 0);
    chk("halt_no_ce", ce_cnt - s, 0);

    // asynchronous reset mid-cycle
    @(negedge clk); #3; rst_n = 1'b0; #1;
    chk("areset_halted", halted, 0);
    chk("areset_rd", bus.q_imem_rd, 0);
    chk("areset_addr", bus.q_imem_addr, 16'h0000);
    chk("areset_pc", pc, 16'h0000);
    lat = 1;
    @(negedge clk); rst_n = 1'b1;
    s = ce_cnt;
    wait_ce(s);
    chk("reboot_instr", ce_instr, 16'h4105);
    chk("reboot_pc", ce_pc, 16'h0000);

    chk("addr_hold", addr_err, 0);
    chk("ce_double", dbl, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
